// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback queue.
// Every queued long-latency result is held as a wb_entry_t. The live bit
// drops when a newer write to the same register makes the entry stale.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fifo_ctrl.sv
// Pointer, occupancy and full/empty bookkeeping for the writeback queue.
// DEPTH is a power of two, so the pointers wrap naturally at their width.
// A push is ignored while full and a pop is ignored while empty, so the
// counters stay consistent whatever the caller requests.
module wbq_fifo_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH)-1:0]   o_wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Advance the pointers and track occupancy; push and pop together leave count unchanged
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: merges single-cycle datapath writes and queued
// long-latency results onto one register-file write port.
// The single-cycle datapath always wins the port; a queued head waits.
// Stale entries are killed instead of removed and drain without writing.
// Optional feature: define WBQ_BYPASS_EN to let a result offered to an
// empty, idle queue write the register file in the same cycle.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_we,
    input  logic [REG_ADDR_W-1:0]   core_rd,
    input  logic [XLEN-1:0]         core_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic [XLEN-1:0]         in_data,
    output logic                    RegWrite,
    output logic [REG_ADDR_W-1:0]   rd,
    output logic [XLEN-1:0]         write_data,
    output logic [NUM_REGS-1:0]     pending,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t          r_entries [DEPTH];
    wb_entry_t          w_head;
    logic [PTR_W-1:0]   w_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_core_kill;
    logic [NUM_REGS-1:0] w_pending;

    wbq_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready;

`ifdef WBQ_BYPASS_EN
    assign w_bypass = w_empty && !core_we && in_valid && (in_rd != '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_accept && (in_rd != '0) && !w_bypass;
    assign w_head      = r_entries[w_rd_ptr];
    assign w_pop       = !w_empty && (!w_head.live || !core_we);
    assign w_core_kill = core_we && (core_rd != '0);

    // Register-file port mux: datapath first, then bypass, then a live queue head
    always_comb begin
        RegWrite   = 1'b0;
        rd         = '0;
        write_data = '0;
        if (core_we) begin
            rd         = core_rd;
            write_data = core_data;
            RegWrite   = (core_rd != '0);
        end else if (w_bypass) begin
            rd         = in_rd;
            write_data = in_data;
            RegWrite   = 1'b1;
        end else if (!w_empty && w_head.live) begin
            rd         = w_head.rd;
            write_data = w_head.data;
            RegWrite   = (w_head.rd != '0);
        end
    end

    // Entry storage: kill stale entries, retire the popped slot, write the new entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_entries[i].live &&
                    ((w_core_kill && (r_entries[i].rd == core_rd)) ||
                     (w_push && (r_entries[i].rd == in_rd)))) begin
                    r_entries[i].live <= 1'b0;
                end
            end
            if (w_pop) begin
                r_entries[w_rd_ptr].live <= 1'b0;
            end
            if (w_push) begin
                r_entries[w_wr_ptr] <= '{live: 1'b1, rd: in_rd, data: in_data};
            end
        end
    end

    // Pending bitmap built only from registered live entries; x0 is never pending
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entries[i].live) begin
                w_pending[r_entries[i].rd] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign pending = w_pending;

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue.
// The reference model keeps the queue as a list of {rd, data, live}
// records and applies the port-priority, kill and drain rules directly.
// Build with WBQ_BYPASS_EN defined to exercise the same-cycle bypass.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int VW    = 1 + 5 + 32 + 1 + 32 + ($clog2(DEPTH) + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } modelEntry_t;

    modelEntry_t mq[$];

    int nTests = 0;
    int nFail  = 0;

    logic        expWe;
    logic [4:0]  expRd;
    logic [31:0] expData;
    logic        expReady;
    logic [31:0] expPending;
    logic [$clog2(DEPTH):0] expCount;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_rd    (core_rd),
        .core_data  (core_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .write_data (write_data),
        .pending    (pending),
        .count      (count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    // Expected port values from the model state and the current inputs
    task automatic computeExpected();
        expWe      = 1'b0;
        expRd      = '0;
        expData    = '0;
        expReady   = (mq.size() < DEPTH);
        expPending = '0;
        expCount   = ($clog2(DEPTH) + 1)'(mq.size());
        if (core_we) begin
            expRd   = core_rd;
            expData = core_data;
            expWe   = (core_rd != 0);
        end
`ifdef WBQ_BYPASS_EN
        else if (mq.size() == 0 && in_valid && in_rd != 0) begin
            expRd   = in_rd;
            expData = in_data;
            expWe   = 1'b1;
        end
`endif
        else if (mq.size() > 0 && mq[0].live) begin
            expRd   = mq[0].rd;
            expData = mq[0].data;
            expWe   = 1'b1;
        end
        foreach (mq[i]) begin
            if (mq[i].live) expPending[mq[i].rd] = 1'b1;
        end
        expPending[0] = 1'b0;
        if (!expWe) begin
            expRd   = '0;
            expData = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs held this cycle
    task automatic modelStep();
        bit accept, bypass, push, pop;
        accept = in_valid && (mq.size() < DEPTH);
`ifdef WBQ_BYPASS_EN
        bypass = (mq.size() == 0) && !core_we && in_valid && (in_rd != 0);
`else
        bypass = 1'b0;
`endif
        push = accept && (in_rd != 0) && !bypass;
        pop  = (mq.size() > 0) && (!mq[0].live || !core_we);
        if (pop) void'(mq.pop_front());
        foreach (mq[i]) begin
            if (core_we && core_rd != 0 && mq[i].rd == core_rd) mq[i].live = 1'b0;
            if (push && mq[i].rd == in_rd) mq[i].live = 1'b0;
        end
        if (push) mq.push_back('{rd: in_rd, data: in_data, live: 1'b1});
    endtask

    function automatic logic [VW-1:0] gotVector();
        return {RegWrite, RegWrite ? rd : 5'd0, RegWrite ? write_data : 32'd0,
                in_ready, pending, count};
    endfunction

    function automatic logic [VW-1:0] expVector();
        return {expWe, expRd, expData, expReady, expPending, expCount};
    endfunction

    // Drive one cycle's inputs just after the falling edge and settle
    task automatic applyIn(input logic we, input logic [4:0] crd, input logic [31:0] cdata,
                           input logic iv, input logic [4:0] ird, input logic [31:0] idata);
        core_we   = we;
        core_rd   = crd;
        core_data = cdata;
        in_valid  = iv;
        in_rd     = ird;
        in_data   = idata;
        #1;
        computeExpected();
    endtask

    // Clock the DUT and the model together, return at the next falling edge
    task automatic advance();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mq.delete();
        applyIn(0, 0, 0, 0, 0, 0);
        nTests++;
        if (gotVector() !== expVector()) begin
            nFail++;
            $display("[TB] FAIL reset_hold: got %h, want %h", gotVector(), expVector());
        end
        @(negedge clk);
        rst = 1'b1;
        applyIn(0, 0, 0, 0, 0, 0);
        nTests++;
        if (gotVector() !== expVector()) begin
            nFail++;
            $display("[TB] FAIL reset_idle: got %h, want %h", gotVector(), expVector());
        end
        advance();
    endtask

    task automatic test_single_push();
        applyIn(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        nTests++;
        if (gotVector() !== expVector()) begin
            nFail++;
            $display("[TB] FAIL push_cycle: got %h, want %h", gotVector(), expVector());
        end
        advance();
        for (int c = 0; c < 2; c++) begin
            applyIn(0, 0, 0, 0, 0, 0);
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL push_drain c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
    endtask

    task automatic test_fill_drain();
        for (int c = 0; c < 4; c++) begin
            applyIn(1, 5'd20, 32'h2000_0000 + c, 1, 5'(c + 1), 32'h1000_0000 + c);
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL fill c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
        applyIn(1, 5'd20, 32'h2000_0004, 1, 5'd9, 32'h9999_9999);
        nTests++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            nFail++;
            $display("[TB] FAIL full_flags: got ready=%b count=%0d, want ready=0 count=4", in_ready, count);
        end
        advance();
        for (int c = 0; c < 5; c++) begin
            applyIn(0, 0, 0, 0, 0, 0);
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL drain c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
    endtask

    task automatic test_core_kill();
        int staleWrites = 0;
        applyIn(1, 5'd20, 32'h0, 1, 5'd10, 32'hCAFEBABE);
        advance();
        applyIn(1, 5'd10, 32'h11111111, 0, 0, 0);
        nTests++;
        if (gotVector() !== expVector()) begin
            nFail++;
            $display("[TB] FAIL core_kill_write: got %h, want %h", gotVector(), expVector());
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            applyIn(0, 0, 0, 0, 0, 0);
            if (RegWrite && write_data == 32'hCAFEBABE) staleWrites++;
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL core_kill_drain c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
        nTests++;
        if (staleWrites !== 0 || pending[10] !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL core_kill_stale: got writes=%0d pend10=%b, want 0 and 0", staleWrites, pending[10]);
        end
    endtask

    task automatic test_waw();
        int x7Writes = 0;
        logic [31:0] lastData = '0;
        applyIn(1, 5'd21, 32'h0, 1, 5'd7, 32'hAAAA_AAAA);
        advance();
        applyIn(1, 5'd21, 32'h0, 1, 5'd7, 32'hBBBB_BBBB);
        advance();
        for (int c = 0; c < 4; c++) begin
            applyIn(0, 0, 0, 0, 0, 0);
            if (RegWrite && rd == 5'd7) begin
                x7Writes++;
                lastData = write_data;
            end
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL waw_drain c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
        nTests++;
        if (x7Writes !== 1 || lastData !== 32'hBBBB_BBBB) begin
            nFail++;
            $display("[TB] FAIL waw_x7: got %0d writes last=%h, want 1 write of BBBBBBBB", x7Writes, lastData);
        end
    endtask

    task automatic test_zero_rd();
        applyIn(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        nTests++;
        if (gotVector() !== expVector()) begin
            nFail++;
            $display("[TB] FAIL zero_push: got %h, want %h", gotVector(), expVector());
        end
        advance();
        applyIn(1, 5'd0, 32'h1234_5678, 0, 0, 0);
        nTests++;
        if (RegWrite !== 1'b0 || count !== 3'd0) begin
            nFail++;
            $display("[TB] FAIL zero_core: got we=%b count=%0d, want we=0 count=0", RegWrite, count);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            applyIn(1, 5'd22, 32'h0, 1, 5'(c + 1), 32'h3000_0000 + c);
            advance();
        end
        applyIn(0, 0, 0, 0, 0, 0);
        nTests++;
        if (gotVector() !== expVector()) begin
            nFail++;
            $display("[TB] FAIL mid_drain: got %h, want %h", gotVector(), expVector());
        end
        advance();
        #1;
        rst = 1'b0;
        #1;
        mq.delete();
        computeExpected();
        nTests++;
        if (count !== 3'd0 || pending !== 32'd0 || RegWrite !== 1'b0 || in_ready !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL mid_reset: got count=%0d pend=%h we=%b ready=%b, want 0 0 0 1",
                     count, pending, RegWrite, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyIn(0, 0, 0, 0, 0, 0);
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL post_reset c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            applyIn($urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL random c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
        for (int c = 0; c < 2 * DEPTH; c++) begin
            applyIn(0, 0, 0, 0, 0, 0);
            nTests++;
            if (gotVector() !== expVector()) begin
                nFail++;
                $display("[TB] FAIL random_drain c%0d: got %h, want %h", c, gotVector(), expVector());
            end
            advance();
        end
    endtask

`ifdef WBQ_BYPASS_EN
    task automatic test_bypass();
        applyIn(0, 0, 0, 1, 5'd3, 32'h0B0B_0303);
        nTests++;
        if (RegWrite !== 1'b1 || rd !== 5'd3 || write_data !== 32'h0B0B_0303) begin
            nFail++;
            $display("[TB] FAIL bypass_same_cycle: got we=%b rd=%0d data=%h, want 1 3 0B0B0303",
                     RegWrite, rd, write_data);
        end
        advance();
        applyIn(0, 0, 0, 0, 0, 0);
        nTests++;
        if (gotVector() !== expVector() || count !== 3'd0) begin
            nFail++;
            $display("[TB] FAIL bypass_no_enqueue: got %h, want %h", gotVector(), expVector());
        end
        advance();
    endtask
`endif

    // Run every scenario in sequence and report
    initial begin
        rst       = 1'b0;
        core_we   = 1'b0;
        core_rd   = '0;
        core_data = '0;
        in_valid  = 1'b0;
        in_rd     = '0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_push();
        test_fill_drain();
        test_core_kill();
        test_waw();
        test_zero_rd();
        test_reset_mid();
        test_random();
`ifdef WBQ_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
